// File: rtl/vlc_switch_cond_pkg.sv
// Shared types and defaults for the tail-lamp switch conditioner.
// Build option: VLC_HAZ_TIMEOUT_EN enables hazard auto-clear in the top.
package vlc_pkg;

  typedef enum logic [1:0] {
    SW_LEFT  = 2'd0,
    SW_RIGHT = 2'd1,
    SW_HAZ   = 2'd2
  } vlc_sw_e;

  localparam int VLC_DB_CYCLES_DEF   = 16;
  localparam int VLC_HAZ_TIMEOUT_DEF = 1024;

  typedef struct packed {
    logic turn_left;
    logic turn_right;
    logic emergency;
  } vlc_req_t;

endpackage

// File: rtl/vlc_switch_cond_if.sv
// Dashboard switch levels in, conditioned sequencer requests out.
interface vlc_switch_cond_if;
  logic sw_left_raw;
  logic sw_right_raw;
  logic sw_hazard_raw;
  logic turn_left;
  logic turn_right;
  logic emergency;
  logic conflict;

  modport master (
    output sw_left_raw, sw_right_raw, sw_hazard_raw,
    input  turn_left, turn_right, emergency, conflict
  );

  modport slave (
    input  sw_left_raw, sw_right_raw, sw_hazard_raw,
    output turn_left, turn_right, emergency, conflict
  );
endinterface

// File: rtl/vlc_switch_cond_debounce.sv
// One switch channel: two-flop synchroniser followed by a consecutive-cycle debouncer.
module vlc_debounce
  import vlc_pkg::*;
#(
  parameter int DB_CYCLES = VLC_DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic stable_o
);

  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // Any cycle agreeing with the stable value restarts the count
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/vlc_switch_cond.sv
// Switch conditioner top: debounced channels, hazard toggle latch, turn resolution.
// Build option: VLC_HAZ_TIMEOUT_EN adds an auto-clear timer on the hazard latch.
module vlc_switch_cond
  import vlc_pkg::*;
#(
  parameter int DB_CYCLES   = VLC_DB_CYCLES_DEF,
  parameter int HAZ_TIMEOUT = VLC_HAZ_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  vlc_switch_cond_if.slave  bus_if
);

  logic [2:0] raw_vec;
  logic [2:0] stable_vec;
  logic       haz_prev_q;
  logic       press_edge;
  logic       emerg_d;
  vlc_req_t   req_q, req_d;
  logic       conflict_q, conflict_d;

  assign raw_vec[SW_LEFT]  = bus_if.sw_left_raw;
  assign raw_vec[SW_RIGHT] = bus_if.sw_right_raw;
  assign raw_vec[SW_HAZ]   = bus_if.sw_hazard_raw;

  for (genvar g = 0; g < 3; g++) begin : g_db
    vlc_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk      (clk),
      .rst      (rst),
      .raw_i    (raw_vec[g]),
      .stable_o (stable_vec[g])
    );
  end

  assign press_edge = stable_vec[SW_HAZ] & ~haz_prev_q;

`ifdef VLC_HAZ_TIMEOUT_EN
  localparam int TO_W = $clog2(HAZ_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(HAZ_TIMEOUT - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            timeout_hit;

  always_comb begin
    emerg_d     = req_q.emergency;
    to_cnt_d    = to_cnt_q;
    timeout_hit = req_q.emergency && (to_cnt_q == TO_LAST);
    // A press landing on the expiry edge keeps the lamp on and restarts the timer
    if (press_edge) begin
      emerg_d  = timeout_hit ? 1'b1 : ~req_q.emergency;
      to_cnt_d = '0;
    end else if (timeout_hit) begin
      emerg_d  = 1'b0;
      to_cnt_d = '0;
    end else if (req_q.emergency) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) to_cnt_q <= '0;
    else     to_cnt_q <= to_cnt_d;
  end
`else
  always_comb begin
    emerg_d = press_edge ? ~req_q.emergency : req_q.emergency;
  end
`endif

  // Turn outputs see the hazard value of this same edge so masking has no lag
  always_comb begin
    req_d            = '0;
    req_d.emergency  = emerg_d;
    req_d.turn_left  = stable_vec[SW_LEFT]  & ~stable_vec[SW_RIGHT] & ~emerg_d;
    req_d.turn_right = stable_vec[SW_RIGHT] & ~stable_vec[SW_LEFT]  & ~emerg_d;
    conflict_d       = stable_vec[SW_LEFT]  &  stable_vec[SW_RIGHT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      haz_prev_q <= 1'b0;
      req_q      <= '0;
      conflict_q <= 1'b0;
    end else begin
      haz_prev_q <= stable_vec[SW_HAZ];
      req_q      <= req_d;
      conflict_q <= conflict_d;
    end
  end

  assign bus_if.turn_left  = req_q.turn_left;
  assign bus_if.turn_right = req_q.turn_right;
  assign bus_if.emergency  = req_q.emergency;
  assign bus_if.conflict   = conflict_q;

endmodule

// File: tb/tb_vlc_switch_cond.sv
// Bench for vlc_switch_cond: directed scenarios plus random switch activity against a cycle model.
module tb_vlc_switch_cond;

  localparam int DB = 4;
  localparam int HT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic left_r = 1'b0, right_r = 1'b0, haz_r = 1'b0;

  int checks = 0;
  int errors = 0;

  vlc_switch_cond_if sw_if ();

  assign sw_if.sw_left_raw   = left_r;
  assign sw_if.sw_right_raw  = right_r;
  assign sw_if.sw_hazard_raw = haz_r;

  vlc_switch_cond #(.DB_CYCLES(DB), .HAZ_TIMEOUT(HT)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (sw_if.slave)
  );

  always #5 clk = ~clk;

  // Reference model: per-channel history of what each switch looked like
  bit m_s1 [3];
  bit m_s2 [3];
  bit m_stab [3];
  int m_run [3];
  bit m_prev;
  bit m_em;
  int m_on_cycles;
  bit m_tl, m_tr, m_cf;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic void model_step();
    bit raw [3];
    bit old_stab [3];
    bit press, expire;
    raw[0] = left_r; raw[1] = right_r; raw[2] = haz_r;
    if (rst) begin
      for (int c = 0; c < 3; c++) begin
        m_s1[c] = 0; m_s2[c] = 0; m_stab[c] = 0; m_run[c] = 0;
      end
      m_prev = 0; m_em = 0; m_on_cycles = 0; m_tl = 0; m_tr = 0; m_cf = 0;
      return;
    end
    for (int c = 0; c < 3; c++) begin
      old_stab[c] = m_stab[c];
      // A synced level must disagree for DB consecutive cycles to be accepted
      if (m_s2[c] != m_stab[c]) begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] == DB) begin
          m_stab[c] = m_s2[c];
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = raw[c];
    end
    press = old_stab[2] && !m_prev;
    m_prev = old_stab[2];
`ifdef VLC_HAZ_TIMEOUT_EN
    expire = m_em && (m_on_cycles == HT - 1);
    if (press) begin
      m_em = expire ? 1'b1 : !m_em;
      m_on_cycles = 0;
    end else if (expire) begin
      m_em = 0;
      m_on_cycles = 0;
    end else if (m_em) begin
      m_on_cycles = m_on_cycles + 1;
    end
`else
    expire = 0;
    if (press) m_em = !m_em;
    if (expire) m_em = 0;
`endif
    m_cf = old_stab[0] && old_stab[1];
    m_tl = old_stab[0] && !old_stab[1] && !m_em;
    m_tr = old_stab[1] && !old_stab[0] && !m_em;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    model_step();
    chk("model_turn_left", sw_if.turn_left, m_tl);
    chk("model_turn_right", sw_if.turn_right, m_tr);
    chk("model_emergency", sw_if.emergency, m_em);
    chk("model_conflict", sw_if.conflict, m_cf);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    ticks(n);
    rst = 1'b0;
  endtask

  task automatic wait_em(input logic val, input int lim, input string tag);
    int k;
    k = 0;
    while (sw_if.emergency !== val && k < lim) begin
      tick();
      k++;
    end
    chk(tag, sw_if.emergency, val);
  endtask

  initial begin
    // 1: everything held through reset
    left_r = 1; right_r = 1; haz_r = 1;
    do_reset(2);
    chk("t1_rst_tl", sw_if.turn_left, 0);
    chk("t1_rst_em", sw_if.emergency, 0);
    chk("t1_rst_cf", sw_if.conflict, 0);
    ticks(6);
    chk("t1_e6_cf", sw_if.conflict, 0);
    chk("t1_e6_em", sw_if.emergency, 0);
    tick();
    chk("t1_e7_cf", sw_if.conflict, 1);
    chk("t1_e7_em", sw_if.emergency, 1);
    chk("t1_e7_tl", sw_if.turn_left, 0);
    chk("t1_e7_tr", sw_if.turn_right, 0);

    // 2: left latency and short glitch
    left_r = 1; right_r = 0; haz_r = 0;
    do_reset(2);
    ticks(6);
    chk("t2_e6_tl", sw_if.turn_left, 0);
    tick();
    chk("t2_e7_tl", sw_if.turn_left, 1);
    left_r = 0;
    ticks(10);
    chk("t2_release_tl", sw_if.turn_left, 0);
    left_r = 1;
    ticks(3);
    left_r = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("t2_glitch_tl", sw_if.turn_left, 0);
    end

    // 3: conflict then right released
    left_r = 1; right_r = 1;
    ticks(10);
    chk("t3_cf", sw_if.conflict, 1);
    chk("t3_cf_tl", sw_if.turn_left, 0);
    chk("t3_cf_tr", sw_if.turn_right, 0);
    right_r = 0;
    ticks(6);
    chk("t3_drop6_tl", sw_if.turn_left, 0);
    tick();
    chk("t3_drop7_tl", sw_if.turn_left, 1);

    // 4: hazard press masks the turn on the same edge
    haz_r = 1;
    ticks(6);
    haz_r = 0;
    wait_em(1'b1, 20, "t4_em_on");
    chk("t4_mask_tl", sw_if.turn_left, 0);
`ifndef VLC_HAZ_TIMEOUT_EN
    ticks(8);
    chk("t4_hold_em", sw_if.emergency, 1);
    haz_r = 1;
    ticks(6);
    haz_r = 0;
    wait_em(1'b0, 20, "t4_em_off");
    chk("t4_unmask_tl", sw_if.turn_left, 1);
`endif

`ifdef VLC_HAZ_TIMEOUT_EN
    // 5: auto-clear with the button still held
    left_r = 0; right_r = 0; haz_r = 1;
    do_reset(2);
    wait_em(1'b1, 20, "t5_em_on");
    for (int i = 1; i <= HT; i++) begin
      tick();
      chk("t5_timeout", sw_if.emergency, (i == HT) ? 0 : 1);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t5_no_retoggle", sw_if.emergency, 0);
    end
    haz_r = 0;
    ticks(8);
    haz_r = 1;
    wait_em(1'b1, 20, "t5_repress");
    haz_r = 0;
`endif

    // 6: reset in the middle of a debounce
    left_r = 1; right_r = 0; haz_r = 0;
    do_reset(2);
    left_r = 0;
    ticks(8);
    left_r = 1;
    ticks(4);
    do_reset(1);
    ticks(6);
    chk("t6_e6_tl", sw_if.turn_left, 0);
    tick();
    chk("t6_e7_tl", sw_if.turn_left, 1);

    // Random switch activity, with occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) left_r  = ~left_r;
      if ($urandom_range(7) == 0) right_r = ~right_r;
      if ($urandom_range(9) == 0) haz_r   = ~haz_r;
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
